// File: rtl/muldiv_seq_pkg.sv
// Shared constants for the iterative MULTU/DIVU sequencer: widths, ALU
// opcodes, MUL/DIV op encoding and the sequencer state type.
package muldiv_seq_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;

  // ALU opcodes shared with the execute-stage ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLLV = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // Sequencer op select
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL_IT = 2'd1,
    ST_DIV_IT = 2'd2,
    ST_DONE   = 2'd3
  } mds_state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/result and shared-ALU signals between the pipeline and muldiv_seq.
interface muldiv_seq_if;
  import muldiv_seq_pkg::*;

  logic             start;
  logic             op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;

  // Sequencer side
  modport slave (
    input  start, op, op_a, op_b, alu_gnt, alu_result,
    output busy, done, div_by_zero, hi, lo, alu_req, alu_a, alu_b, alu_control
  );

  // Pipeline / ALU-mux side
  modport master (
    output start, op, op_a, op_b, alu_gnt, alu_result,
    input  busy, done, div_by_zero, hi, lo, alu_req, alu_a, alu_b, alu_control
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply/divide. Borrows the shared ALU for the
// add (shift-add multiply) or subtract (restoring divide) of each of the
// 32 iterations; an iteration only advances on an edge where the ALU is granted.
module muldiv_seq
  import muldiv_seq_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  mds_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_opb;      // multiplicand (MUL) or divisor (DIV)
  logic             r_dbz;

  logic             w_accept, w_step, w_last;
  logic             w_alu_req;
  logic [WIDTH-1:0] w_alu_a, w_alu_b;
  logic [3:0]       w_alu_ctl;
  logic             w_carry, w_borrow, w_take;
  logic [WIDTH-1:0] w_rem_sh;   // low 32 bits of {hi, lo[31]}

  assign w_accept = (r_state == ST_IDLE) && bus.start;
  assign w_step   = w_alu_req && bus.alu_gnt;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_rem_sh = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and ALU-facing outputs; ALU operands are zero unless requesting
  always_comb begin
    w_state_nxt = r_state;
    w_alu_req   = 1'b0;
    w_alu_a     = '0;
    w_alu_b     = '0;
    w_alu_ctl   = ALU_AND;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op == OP_MULTU)     w_state_nxt = ST_MUL_IT;
          else if (bus.op_b == '0)    w_state_nxt = ST_DONE;
          else                        w_state_nxt = ST_DIV_IT;
        end
      end
      ST_MUL_IT: begin
        w_alu_req = 1'b1;
        w_alu_a   = r_hi;
        w_alu_b   = r_opb;
        w_alu_ctl = ALU_ADD;
        if (bus.alu_gnt && w_last) w_state_nxt = ST_DONE;
      end
      ST_DIV_IT: begin
        w_alu_req = 1'b1;
        w_alu_a   = w_rem_sh;
        w_alu_b   = r_opb;
        w_alu_ctl = ALU_SUB;
        if (bus.alu_gnt && w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Carry out of the add and borrow of the subtract, derived locally since
  // the shared ALU only returns the 32-bit result
  always_comb begin
    w_carry  = (bus.alu_result < r_hi);
    w_borrow = (w_rem_sh < r_opb);
    w_take   = r_hi[WIDTH-1] | ~w_borrow;
  end

  // Operand latch on accept, then one shift-add / restoring step per granted edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_opb <= '0;
      r_dbz <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_dbz <= 1'b0;
      if (bus.op == OP_MULTU) begin
        r_hi  <= '0;
        r_lo  <= bus.op_b;
        r_opb <= bus.op_a;
      end else if (bus.op_b == '0) begin
        r_hi  <= bus.op_a;
        r_lo  <= '1;
        r_dbz <= 1'b1;
      end else begin
        r_hi  <= '0;
        r_lo  <= bus.op_a;
        r_opb <= bus.op_b;
      end
    end else if (w_step) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_state == ST_MUL_IT) begin
        if (r_lo[0]) begin
          r_hi <= {w_carry, bus.alu_result[WIDTH-1:1]};
          r_lo <= {bus.alu_result[0], r_lo[WIDTH-1:1]};
        end else begin
          r_hi <= {1'b0, r_hi[WIDTH-1:1]};
          r_lo <= {r_hi[0], r_lo[WIDTH-1:1]};
        end
      end else begin
        r_hi <= w_take ? bus.alu_result : w_rem_sh;
        r_lo <= {r_lo[WIDTH-2:0], w_take};
      end
    end
  end

  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = (r_state == ST_DONE);
  assign bus.div_by_zero = r_dbz;
  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.alu_req     = w_alu_req;
  assign bus.alu_a       = w_alu_a;
  assign bus.alu_b       = w_alu_b;
  assign bus.alu_control = w_alu_ctl;

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: behavioural ALU, directed corner cases plus random
// MULTU/DIVU with random grant, checked against plain 64-bit arithmetic.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  muldiv_seq_if bus ();

  muldiv_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Shared ALU stand-in, combinational
  always_comb begin
    case (bus.alu_control)
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      default: bus.alu_result = bus.alu_a & bus.alu_b;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // gmode: 0 grant always, 1 alternate 1,0,1,0, 2 random
  // inject: pulse start with other operands while busy
  task automatic run_op(input string tag, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input int gmode, input bit inject);
    logic [63:0] prod;
    logic [31:0] exp_hi, exp_lo;
    logic        exp_dbz, req_seen, stable_ok, ctl_ok, tog;
    logic [31:0] sa, sb;
    logic [3:0]  sc;
    int          n, g;
    bit          held, seen_done;

    if (op == OP_MULTU) begin
      prod = {32'd0, a} * {32'd0, b};
      exp_hi = prod[63:32]; exp_lo = prod[31:0]; exp_dbz = 1'b0;
    end else if (b == 0) begin
      exp_hi = a; exp_lo = 32'hFFFF_FFFF; exp_dbz = 1'b1;
    end else begin
      exp_hi = a % b; exp_lo = a / b; exp_dbz = 1'b0;
    end

    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ".busy_after_accept"}, 64'(bus.busy), 64'd1);
    chk({tag, ".dbz_after_accept"}, 64'(bus.div_by_zero), 64'(exp_dbz));

    n = 0; g = 0; req_seen = 1'b0; stable_ok = 1'b1; ctl_ok = 1'b1; tog = 1'b1;
    while (!bus.done && n < 300) begin
      @(negedge clk);
      case (gmode)
        0:       bus.alu_gnt = 1'b1;
        1:       begin bus.alu_gnt = tog; tog = ~tog; end
        default: bus.alu_gnt = ($urandom_range(0, 3) != 0);
      endcase
      if (inject && n == 5) begin
        bus.start = 1'b1; bus.op = ~op; bus.op_a = 32'hDEAD_BEEF; bus.op_b = 32'd3;
      end
      if (bus.alu_req) begin
        req_seen = 1'b1;
        if (bus.alu_control !== ((op == OP_MULTU) ? ALU_ADD : ALU_SUB)) ctl_ok = 1'b0;
      end
      if (bus.alu_req && bus.alu_gnt) g++;
      held = bus.alu_req && !bus.alu_gnt;
      sa = bus.alu_a; sb = bus.alu_b; sc = bus.alu_control;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n++;
      if (held && !(bus.alu_a === sa && bus.alu_b === sb && bus.alu_control === sc))
        stable_ok = 1'b0;
    end

    chk({tag, ".done_seen"}, 64'(bus.done), 64'd1);
    chk({tag, ".busy_in_done"}, 64'(bus.busy), 64'd1);
    chk({tag, ".hi"}, 64'(bus.hi), 64'(exp_hi));
    chk({tag, ".lo"}, 64'(bus.lo), 64'(exp_lo));
    chk({tag, ".dbz"}, 64'(bus.div_by_zero), 64'(exp_dbz));
    if (exp_dbz) begin
      chk({tag, ".latency"}, 64'(n), 64'd0);
      chk({tag, ".req_never"}, 64'(req_seen), 64'd0);
    end else begin
      chk({tag, ".granted_edges"}, 64'(g), 64'd32);
      chk({tag, ".alu_ctl"}, 64'(ctl_ok), 64'd1);
      if (gmode == 0) chk({tag, ".latency"}, 64'(n), 64'd32);
      if (gmode != 0) chk({tag, ".alu_hold"}, 64'(stable_ok), 64'd1);
    end

    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, 64'({bus.done, bus.busy}), 64'd0);
    if (inject) begin
      seen_done = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (bus.done || bus.busy) seen_done = 1'b1;
      end
      chk({tag, ".no_second_run"}, 64'(seen_done), 64'd0);
      chk({tag, ".hold_result"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.alu_gnt = 1'b0;
    #1;
    chk("reset.outs", {bus.hi, bus.lo}, 64'd0);
    chk("reset.flags", 64'({bus.busy, bus.done, bus.div_by_zero, bus.alu_req}), 64'd0);
    chk("reset.alu", {bus.alu_a, bus.alu_b, 28'd0, bus.alu_control}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("mul5x10", OP_MULTU, 32'd5, 32'd10, 0, 1'b0);
    run_op("mul_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("div100_7", OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    run_op("div_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op("div_zero", OP_DIVU, 32'h1234, 32'd0, 0, 1'b0);
    run_op("mul7x9_tog", OP_MULTU, 32'd7, 32'd9, 1, 1'b0);

    // Reset mid-run
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.op_a = 32'h1357_9BDF; bus.op_b = 32'h2468_ACE0;
    bus.alu_gnt = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.hilo", {bus.hi, bus.lo}, 64'd0);
    chk("midrst.flags", 64'({bus.busy, bus.done, bus.div_by_zero, bus.alu_req}), 64'd0);
    chk("midrst.alu", {bus.alu_a, bus.alu_b, 28'd0, bus.alu_control}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div9_2_inj", OP_DIVU, 32'd9, 32'd2, 0, 1'b1);

    // Random operations under random grant
    for (int i = 0; i < 8; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom();
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom();
      run_op($sformatf("rnd%0d", i), 1'(i % 2), ra, rb, 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
